// File: rtl/i2c_slave.sv
// i2c_slave: oversampled open-drain I2C target with a fixed 7-bit address, byte write/read handshakes to local logic
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_req,
    output logic       o_busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;
    state_t state_q, state_d;
    logic [2:0] scl_q, scl_d, sda_q, sda_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic rw_q, rw_d, done_q, done_d, oe_q, oe_d, busy_q, busy_d;
    logic rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
    logic scl_hi, scl_rise, scl_fall, sda_s, start, stop;
    // [1] is the synchronised level, [2] its previous value
    assign scl_d    = {scl_q[1:0], i_scl};
    assign sda_d    = {sda_q[1:0], i_sda};
    assign sda_s    = sda_q[1];
    assign scl_hi   = scl_q[1] & scl_q[2];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_hi & ~sda_q[1] & sda_q[2];
    assign stop     = scl_hi & sda_q[1] & ~sda_q[2];
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        done_d     = done_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, WR_DATA: begin
                    // done_q marks a complete byte waiting for the fall that opens the ACK slot
                    if (scl_rise && !done_q) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            done_d = 1'b1;
                            if (state_q == ADDR) begin
                                rw_d = sda_s;
                                if (shift_q[6:0] != SLV_ADDR) begin
                                    state_d = IDLE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b0;
                                end
                            end else begin
                                rx_data_d  = {shift_q[6:0], sda_s};
                                rx_valid_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        oe_d    = 1'b1;
                        done_d  = 1'b0;
                        busy_d  = (state_q == ADDR) ? 1'b1 : busy_q;
                        state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    cnt_d    = 3'd0;
                    done_d   = 1'b0;
                    shift_d  = rw_q ? i_tx_data : shift_q;
                    tx_req_d = rw_q;
                    oe_d     = rw_q ? ~i_tx_data[7] : 1'b0;
                    state_d  = rw_q ? RD_DATA : WR_DATA;
                end
                WR_ACK: if (scl_fall) begin
                    oe_d    = 1'b0;
                    cnt_d   = 3'd0;
                    done_d  = 1'b0;
                    state_d = WR_DATA;
                end
                RD_DATA: if (scl_fall) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    oe_d    = (cnt_q == 3'd7) ? 1'b0 : ~shift_q[6];
                    state_d = (cnt_q == 3'd7) ? RD_ACK : RD_DATA;
                    done_d  = 1'b0;
                end
                RD_ACK: begin
                    if (scl_rise && !done_q) begin
                        done_d  = ~sda_s;
                        busy_d  = ~sda_s;
                        state_d = sda_s ? IDLE : RD_ACK;
                    end else if (scl_fall && done_q) begin
                        shift_d  = i_tx_data;
                        tx_req_d = 1'b1;
                        oe_d     = ~i_tx_data[7];
                        cnt_d    = 3'd0;
                        done_d   = 1'b0;
                        state_d  = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            scl_q      <= 3'b111;
            sda_q      <= 3'b111;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            done_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            done_q     <= done_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end
    assign o_sda_oe   = oe_q;
    assign o_busy     = busy_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_tx_req   = tx_req_q;
endmodule
